// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register slave.
//   DATA_W / ADDR_W : APB data and address widths
//   CNT_W           : width of the ACCESS wait counter
//   ADDR_ID/ADDR_WO : read-only ID register and write-only register addresses
//   apb_state_e     : slave FSM states
//   apb_req_t       : transfer fields captured from the setup phase
package apb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ADDR_W-1:0] ADDR_ID = 32'h04;
    localparam logic [ADDR_W-1:0] ADDR_WO = 32'h08;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable 4-bit down-counter with registered zero flag; stops at zero.
//   clk, rst_n   : clock, async active-low reset (count 0, zero flag 1)
//   load_i       : load load_val_i (has priority over dec_i)
//   dec_i        : decrement by one while non-zero
//   cnt_o        : current count
//   zero_o       : high while the count is zero
module apb_wait_ctr
    import apb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q;

    // Next count: load wins, otherwise saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_q) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = zero_q;

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave with a bank of 32-bit registers, a read-only ID word at 0x04,
// a write-only word at 0x08 and a programmable number of wait states.
//   pclk, presetn           : clock, async active-low reset
//   psel, penable, pwrite   : APB control
//   paddr, pwdata           : APB byte address and write data
//   pready                  : one-cycle completion pulse
//   prdata, pslverr         : read data / error, non-zero only with pready
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter int unsigned       NUM_REGS    = 16,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr
);

    localparam int unsigned       IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);
    localparam logic [CNT_W-1:0]  WAIT_LD    = CNT_W'(WAIT_CYCLES);

    apb_state_e        state_q, state_d;
    apb_req_t          req_q, req_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] bank_q [NUM_REGS];

    logic              go;
    logic              ctr_load, ctr_dec, ctr_zero;
    logic [CNT_W-1:0]  ctr_cnt;
    logic              addr_err;
    logic              wr_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_val;

    apb_wait_ctr u_wait_ctr (
        .clk        (pclk),
        .rst_n      (presetn),
        .load_i     (ctr_load),
        .dec_i      (ctr_dec),
        .load_val_i (WAIT_LD),
        .cnt_o      (ctr_cnt),
        .zero_o     (ctr_zero)
    );

    // Decode of the captured request.
    always_comb begin
        idx      = req_q.addr[2 +: IDX_W];
        addr_err = (req_q.addr[1:0] != 2'b00)
                || (req_q.addr >= ADDR_LIMIT)
                || ( req_q.write && (req_q.addr == ADDR_ID))
                || (!req_q.write && (req_q.addr == ADDR_WO));
        rd_val   = (req_q.addr == ADDR_ID) ? ID_VALUE : bank_q[idx];
    end

    // Next state and response. Responses are computed one cycle early so that
    // pready/prdata/pslverr come straight from flops.
    always_comb begin
        go        = psel && penable;
        state_d   = state_q;
        req_d     = req_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // penable without a preceding setup phase is ignored
                if (psel && !penable) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (go) begin
                    state_d  = ST_ACCESS;
                    ctr_load = 1'b1;
                    pready_d = (WAIT_CYCLES == 0);
                end else if (psel) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (ctr_zero) begin
                    // completion cycle (pready high now)
                    state_d = (psel && !penable) ? ST_SETUP : ST_IDLE;
                end else if (go) begin
                    ctr_dec  = 1'b1;
                    pready_d = (ctr_cnt == CNT_W'(1));
                end else begin
                    // master withdrew before completion
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_SETUP) begin
            req_d = '{addr: paddr, write: pwrite, wdata: pwdata};
        end

        if (pready_d) begin
            pslverr_d = addr_err;
            if (!req_q.write && !addr_err) prdata_d = rd_val;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Writes land at the end of an error-free completion cycle.
    assign wr_en = pready_q && req_q.write && !pslverr_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
        end else if (wr_en) begin
            bank_q[idx] <= req_q.wdata;
        end
    end

    assign pready  = pready_q;
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
module tb_apb_slave_regs;

    localparam int          W0     = 2;
    localparam int          W1     = 0;
    localparam logic [31:0] ID_VAL = 32'hA5B0_0001;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [2][16];

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   pen_cyc  [2];
    logic pen_prev [2];
    logic rdy_prev [2];

    always #5 clk = ~clk;

    apb_slave_regs #(.WAIT_CYCLES(W0), .NUM_REGS(16), .ID_VALUE(ID_VAL)) u_dut0 (
        .pclk(clk), .presetn(rst_n), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
    );

    apb_slave_regs #(.WAIT_CYCLES(W1), .NUM_REGS(16), .ID_VALUE(ID_VAL)) u_dut1 (
        .pclk(clk), .presetn(rst_n), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: register file semantics from the address map.
    function automatic exp_t predict(input int d, input logic wr, input logic [31:0] addr,
                                     input logic [31:0] data);
        exp_t e;
        logic bad;
        bad = (addr % 4 != 0) || (addr >= 32'd64) || (wr && addr == 32'd4) || (!wr && addr == 32'd8);
        e.err   = bad;
        e.rdata = '0;
        e.lat   = ((d == 0) ? W0 : W1) + 1;
        if (!bad) begin
            if (wr) model[d][addr[5:2]] = data;
            else    e.rdata = (addr == 32'd4) ? ID_VAL : model[d][addr[5:2]];
        end
        return e;
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drop(input int d);
        if (d == 0 && q0.size() > 0) void'(q0.pop_back());
        if (d == 1 && q1.size() > 0) void'(q1.pop_back());
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) model[d][i] = '0;
    endtask

    task automatic wait_ready(input int d, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n <= 40) begin
            @(negedge clk);
            if (pready[d]) ok = 1'b1;
            else           n++;
        end
        if (!ok) begin
            n_checks++;
            n_fails++;
            $display("FAIL ready_timeout dut%0d: pready stayed 0 for 40 cycles, expected a pulse", d);
            drop(d);
        end
    endtask

    // One APB transfer; b2b leaves psel high so the next call starts a setup immediately.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit b2b);
        bit ok;
        push(d, predict(d, wr, addr, data));
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite     = wr;
        paddr      = addr;
        pwdata     = data;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        wait_ready(d, ok);
        @(posedge clk); #1;
        if (!b2b) begin
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        if (k <= 6)       a = 32'($urandom_range(0, 15)) << 2;
        else if (k == 7)  a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        else if (k == 8)  a = 32'h40 + (32'($urandom_range(0, 63)) << 2);
        else              a = $urandom;
        return a;
    endfunction

    // Monitor: pops an expectation on every pready pulse, checks idle outputs otherwise.
    always @(negedge clk) begin
        exp_t e;
        logic act;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            act = psel[d] && penable[d];
            if (act && !pen_prev[d]) pen_cyc[d] = cyc;
            pen_prev[d] = act;
            if (rst_n === 1'b1) begin
                if (pready[d]) begin
                    check($sformatf("pready_single_cycle dut%0d", d), 32'(rdy_prev[d]), 32'd0);
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected_pready dut%0d: pready=1 with no transfer pending", d);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("prdata dut%0d", d),  prdata[d],           e.rdata);
                        check($sformatf("pslverr dut%0d", d), 32'(pslverr[d]),     32'(e.err));
                        check($sformatf("latency dut%0d", d), 32'(cyc - pen_cyc[d]), 32'(e.lat));
                    end
                end else begin
                    check($sformatf("idle_prdata dut%0d", d),  prdata[d],       32'd0);
                    check($sformatf("idle_pslverr dut%0d", d), 32'(pslverr[d]), 32'd0);
                end
            end
            rdy_prev[d] = pready[d];
        end
    end

    initial begin
        bit   ok;
        bit   prev_b2b;
        int   d;
        logic wr;
        logic [31:0] a;
        logic [31:0] v;

        rst_n  = 1'b0;
        pwrite = 1'b0;
        paddr  = '0;
        pwdata = '0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0;
            pen_prev[i] = 1'b0; rdy_prev[i] = 1'b0; pen_cyc[i] = 0;
        end
        clear_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_pready dut%0d", i),  32'(pready[i]),  32'd0);
            check($sformatf("reset_prdata dut%0d", i),  prdata[i],       32'd0);
            check($sformatf("reset_pslverr dut%0d", i), 32'(pslverr[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed address-map cases
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0,         1'b0);
        xfer(0, 1'b1, 32'h04, 32'h0000_1234, 1'b0);
        xfer(0, 1'b0, 32'h04, 32'h0,         1'b0);
        xfer(0, 1'b1, 32'h08, 32'h0000_0055, 1'b0);
        xfer(0, 1'b0, 32'h08, 32'h0,         1'b0);
        xfer(0, 1'b0, 32'h40, 32'h0,         1'b0);
        xfer(0, 1'b0, 32'h11, 32'h0,         1'b0);
        xfer(0, 1'b1, 32'h11, 32'h7777_7777, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0,         1'b0);

        // Back-to-back on the zero-wait instance
        xfer(1, 1'b1, 32'h0C, 32'h1111_0C0C, 1'b1);
        xfer(1, 1'b1, 32'h14, 32'h2222_1414, 1'b1);
        xfer(1, 1'b0, 32'h0C, 32'h0,         1'b1);
        xfer(1, 1'b0, 32'h14, 32'h0,         1'b0);

        // Randomized traffic; a back-to-back burst stays on one instance
        prev_b2b = 1'b0;
        d = 0;
        for (int i = 0; i < 160; i++) begin
            bit b2b;
            if (!prev_b2b) d = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            a   = rand_addr();
            v   = $urandom;
            b2b = (i != 159) && ($urandom_range(0, 2) == 0);
            xfer(d, wr, a, v, b2b);
            if (!b2b) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            prev_b2b = b2b;
        end

        // Abort during wait states: no write may happen
        xfer(0, 1'b1, 32'h20, 32'h0000_2020, 1'b0);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hBAD0_0020;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        xfer(0, 1'b0, 32'h20, 32'h0, 1'b0);

        // penable without setup phase must be ignored
        pwrite = 1'b1; paddr = 32'h24; pwdata = 32'hCAFE_0024;
        psel[0] = 1'b1; penable[0] = 1'b1;
        psel[1] = 1'b1; penable[1] = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        for (int i = 0; i < 2; i++) begin psel[i] = 1'b0; penable[i] = 1'b0; end
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h24, 32'h0, 1'b0);
        xfer(1, 1'b0, 32'h24, 32'h0, 1'b0);

        // Reset landing on a live read response clears outputs at once
        push(0, predict(0, 1'b0, 32'h04, 32'h0));
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite = 1'b0; paddr = 32'h04;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        wait_ready(0, ok);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_pready",  32'(pready[0]),  32'd0);
        check("async_rst_prdata",  prdata[0],       32'd0);
        check("async_rst_pslverr", 32'(pslverr[0]), 32'd0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset during ACCESS of a write: abandoned, bank cleared
        xfer(1, 1'b1, 32'h0C, 32'h0C0C_5A5A, 1'b0);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_access_pready",  32'(pready[0]),  32'd0);
        check("rst_access_prdata",  prdata[0],       32'd0);
        check("rst_access_pslverr", 32'(pslverr[0]), 32'd0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h18, 32'h0, 1'b0);
        xfer(1, 1'b0, 32'h0C, 32'h0, 1'b0);
        xfer(0, 1'b1, 32'h18, 32'h0000_FFFF, 1'b0);
        xfer(0, 1'b0, 32'h18, 32'h0, 1'b0);

        repeat (5) @(posedge clk);
        check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning ACCESS-phase cycles with pready low before completion (legal 0..15).
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning number of 32-bit registers, word-addressed by paddr[5:2].
REQ-003 SHALL have parameter ID_VALUE, default 32'hA5B0_0001, meaning the constant returned by the read-only register.
REQ-004 pclk  input  1  APB clock; all logic on rising edge.
REQ-005 presetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 psel  input  1  slave select.
REQ-007 penable  input  1  access-phase strobe.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  32  byte address.
REQ-010 pwdata  input  32  write data.
REQ-011 pready  output  1  transfer completion, high exactly one cycle per transfer.
REQ-012 prdata  output  32  read data, valid only while pready=1 and pwrite=0.
REQ-013 pslverr  output  1  error response, valid only while pready=1.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE, state enum from the package.
REQ-015 IDLE -> SETUP when psel=1 and penable=0; SETUP -> ACCESS when psel=1 and penable=1 the next cycle.
REQ-016 In SETUP, paddr, pwrite, pwdata SHALL be captured into internal registers; ACCESS uses the captured values only.
REQ-017 In ACCESS, a wait counter SHALL load WAIT_CYCLES on entry and decrement each cycle; pready=1 in the cycle the count is 0 (WAIT_CYCLES=0 -> pready in first ACCESS cycle).
REQ-018 Latency SHALL be exactly WAIT_CYCLES+1 ACCESS cycles from penable rising to pready high.
REQ-019 Cycle after pready=1 SHALL have pready=0, prdata=0, pslverr=0; FSM returns to IDLE, or to SETUP if psel=1 and penable=0 (back-to-back).
REQ-020 Write SHALL commit to the register bank on the pready cycle only, and only if pslverr=0.
REQ-021 pslverr=1 on completion when: write to 0x04 (read-only ID), read of 0x08 (write-only), paddr >= NUM_REGS*4, or paddr[1:0] != 0.
REQ-022 Error reads SHALL return prdata=0; error writes SHALL leave all registers unchanged.
REQ-023 Read of 0x04 SHALL return ID_VALUE; read of any other legal address SHALL return stored content.
REQ-024 psel=0 or penable=0 while in ACCESS before pready SHALL abort to IDLE with no write, pready=0, pslverr=0.
REQ-025 penable=1 in IDLE (no SETUP phase) SHALL be ignored: no pready, no state change.
REQ-026 prdata and pslverr SHALL be 0 in every cycle where pready=0.

Reset
REQ-027 presetn=0 SHALL asynchronously force FSM=IDLE, wait counter=0, pready=0, prdata=0, pslverr=0, capture registers=0, all bank registers=0.
REQ-028 Reset asserted mid-transfer SHALL abandon it with no write; first transfer after release needs a full SETUP phase.

Structure
REQ-029 Package apb_pkg SHALL hold the state enum, ADDR_ID=32'h04, ADDR_WO=32'h08, and data/address width constants.
REQ-030 One sub-module apb_wait_ctr (4-bit loadable down-counter with zero flag, async active-low reset) SHALL be instantiated; register bank and decode stay in apb_slave_regs.

Verification
REQ-031 Write 0x10 <- 32'hDEAD_BEEF, then read 0x10 with WAIT_CYCLES=2 -> pready after 3 ACCESS cycles, prdata=32'hDEAD_BEEF, pslverr=0.
REQ-032 Write 0x04 <- 32'h1234 -> pslverr=1 on pready; read 0x04 -> prdata=32'hA5B0_0001, pslverr=0.
REQ-033 Write 0x08 <- 32'h55 then read 0x08 -> write pslverr=0; read pslverr=1, prdata=0.
REQ-034 Read 0x40 and read 0x11 -> pslverr=1, prdata=0, no register changed.
REQ-035 Back-to-back writes 0x0C, 0x14 with WAIT_CYCLES=0 -> each pready one cycle, both values read back.
REQ-036 presetn low during ACCESS of write 0x18 <- 32'hFFFF -> outputs 0 immediately; read 0x18 after release returns 0.
